// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared defaults and width helper for the sequence detector
package seq_detect_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

    // Width needed to hold a length value in 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// rtl/seq_prefix_match.sv - longest pattern prefix that ends the received history
//
// Ports:
//   history : received bits, bit 0 newest
//   pattern : pattern bits, bit len-1 is the first pattern bit
//   len     : active pattern length (already clamped to PAT_W)
//   fill    : number of valid history bits
//   k       : largest j <= min(fill, len) with history[j-1:0] == pattern[len-1:len-j]
module seq_prefix_match
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic [PAT_W-1:0]               history,
    input  logic [PAT_W-1:0]               pattern,
    input  logic [len_width(PAT_W)-1:0]    len,
    input  logic [len_width(PAT_W)-1:0]    fill,
    output logic [len_width(PAT_W)-1:0]    k
);

    localparam int LW = len_width(PAT_W);

    always_comb begin : find_k
        int   lim;
        int   idx;
        logic ok;
        lim = (fill < len) ? int'(fill) : int'(len);
        idx = 0;
        ok  = 1'b0;
        k   = '0;
        // Candidates are tried in increasing length so the last hit is the longest.
        for (int j = 1; j <= PAT_W; j++) begin
            ok = (j <= lim);
            for (int i = 0; i < PAT_W; i++) begin
                if (i < j) begin
                    // Newest bit history[0] lines up with the last bit of the j-prefix.
                    idx = int'(len) - j + i;
                    if (idx < 0 || idx >= PAT_W) begin
                        ok = 1'b0;
                    end else if (history[i] != pattern[idx]) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                k = LW'(j);
            end
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable serial pattern detector with match pulse and counter
//
// Optional feature macro: SEQ_MATCH_CNT_EN (match counter and cnt_clr; tied off when undefined)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   in        : serial data bit, sampled when in_valid is high
//   in_valid  : qualifies in
//   load      : latch pat/pat_len, restart detection, drop the current in bit
//   pat       : pattern, bit pat_len-1 received first
//   pat_len   : pattern length, 0 disables, values above PAT_W treated as PAT_W
//   overlap   : 1 lets matching bits be reused by the next match
//   cnt_clr   : clear the match counter (wins over a simultaneous match)
//   out       : one-cycle pulse the cycle after a matching edge
//   statout   : current matched-prefix length
//   match_cnt : saturating match count
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic                         in_valid,
    input  logic                         load,
    input  logic [PAT_W-1:0]             pat,
    input  logic [len_width(PAT_W)-1:0]  pat_len,
    input  logic                         overlap,
    input  logic                         cnt_clr,
    output logic                         out,
    output logic [len_width(PAT_W)-1:0]  statout,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int LW = len_width(PAT_W);

    logic [PAT_W-1:0] pat_r;
    logic [LW-1:0]    len_r;
    logic [PAT_W-1:0] hist_r;
    logic [LW-1:0]    fill_r;
    logic [LW-1:0]    stat_r;
    logic             out_r;

    logic [PAT_W-1:0] hist_nx;
    logic [LW-1:0]    fill_inc;
    logic [LW-1:0]    k;
    logic             match;
    logic             match_ev;

    assign hist_nx  = {hist_r[PAT_W-2:0], in};
    assign fill_inc = (fill_r == LW'(PAT_W)) ? fill_r : fill_r + 1'b1;

    seq_prefix_match #(
        .PAT_W (PAT_W)
    ) u_prefix (
        .history (hist_nx),
        .pattern (pat_r),
        .len     (len_r),
        .fill    (fill_inc),
        .k       (k)
    );

    // A full-length prefix is a match; k is already limited by fill, so this
    // also enforces that enough bits have arrived.
    assign match    = (len_r != '0) && (k == len_r);
    assign match_ev = in_valid && !load && match;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_r  <= '0;
            len_r  <= '0;
            hist_r <= '0;
            fill_r <= '0;
            stat_r <= '0;
            out_r  <= 1'b0;
        end else if (load) begin
            pat_r  <= pat;
            len_r  <= (pat_len > LW'(PAT_W)) ? LW'(PAT_W) : pat_len;
            fill_r <= '0;
            stat_r <= '0;
            out_r  <= 1'b0;
        end else if (in_valid) begin
            hist_r <= hist_nx;
            fill_r <= (match && !overlap) ? '0 : fill_inc;
            stat_r <= k;
            out_r  <= match;
        end else begin
            out_r  <= 1'b0;
        end
    end

    assign out     = out_r;
    assign statout = stat_r;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (match_ev && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign match_cnt = cnt_r;
`else
    logic unused_cnt;
    assign unused_cnt = &{1'b0, cnt_clr, match_ev};
    assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pat;
    logic [LW-1:0]    pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             out;
    logic [LW-1:0]    statout;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .load      (load),
        .pat       (pat),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .out       (out),
        .statout   (statout),
        .match_cnt (match_cnt)
    );

    function automatic int exp_cnt(input int n);
`ifdef SEQ_MATCH_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one bit, then check the pulse and prefix length registered on that edge.
    task automatic send(input string tag, input logic b, input int e_out, input int e_stat);
        in_valid = 1'b1;
        in       = b;
        tick();
        in_valid = 1'b0;
        check({tag, ".out"}, int'(out), e_out);
        check({tag, ".stat"}, int'(statout), e_stat);
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l);
        load    = 1'b1;
        pat     = p;
        pat_len = l;
        tick();
        load    = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in = 1'b0; in_valid = 1'b0; load = 1'b0;
        pat = '0; pat_len = '0; overlap = 1'b1; cnt_clr = 1'b0;
        tick();
        tick();
        check("rst.out", int'(out), 0);
        check("rst.stat", int'(statout), 0);
        check("rst.cnt", int'(match_cnt), 0);
        rst = 1'b1;

        // No pattern loaded yet: detection disabled.
        send("nolen", 1'b1, 0, 0);

        // Pattern 101011, overlapping, with an idle cycle that must hold state.
        overlap = 1'b1;
        do_load(8'b0010_1011, 4'd6);
        check("ld33.stat", int'(statout), 0);
        send("s33.b1", 1'b1, 0, 1);
        send("s33.b2", 1'b0, 0, 2);
        send("s33.b3", 1'b1, 0, 3);
        send("s33.b4", 1'b0, 0, 4);
        send("s33.b5", 1'b1, 0, 5);
        tick();
        check("idle.out", int'(out), 0);
        check("idle.stat", int'(statout), 5);
        send("s33.b6", 1'b0, 0, 4);
        send("s33.b7", 1'b1, 0, 5);
        send("s33.b8", 1'b0, 0, 4);
        send("s33.b9", 1'b1, 0, 5);
        send("s33.b10", 1'b1, 1, 6);
        check("s33.cnt", int'(match_cnt), exp_cnt(1));
        tick();
        check("s33.pulse_end", int'(out), 0);
        clear_cnt();
        check("clr.cnt", int'(match_cnt), 0);

        // Pattern 11: overlapping then non-overlapping.
        overlap = 1'b1;
        do_load(8'b11, 4'd2);
        send("ov1.b1", 1'b1, 0, 1);
        send("ov1.b2", 1'b1, 1, 2);
        send("ov1.b3", 1'b1, 1, 2);
        send("ov1.b4", 1'b1, 1, 2);
        check("ov1.cnt", int'(match_cnt), exp_cnt(3));
        clear_cnt();
        overlap = 1'b0;
        do_load(8'b11, 4'd2);
        send("ov0.b1", 1'b1, 0, 1);
        send("ov0.b2", 1'b1, 1, 2);
        send("ov0.b3", 1'b1, 0, 1);
        send("ov0.b4", 1'b1, 1, 2);
        check("ov0.cnt", int'(match_cnt), exp_cnt(2));
        clear_cnt();

        // Reload mid-stream with a valid bit present: that bit is dropped.
        overlap = 1'b1;
        do_load(8'b0010_1011, 4'd6);
        send("p35.b1", 1'b1, 0, 1);
        send("p35.b2", 1'b0, 0, 2);
        send("p35.b3", 1'b1, 0, 3);
        send("p35.b4", 1'b0, 0, 4);
        send("p35.b5", 1'b1, 0, 5);
        in_valid = 1'b1; in = 1'b1;
        do_load(8'b011, 4'd3);
        in_valid = 1'b0;
        check("ld35.stat", int'(statout), 0);
        check("ld35.out", int'(out), 0);
        send("s35.b1", 1'b0, 0, 1);
        send("s35.b2", 1'b1, 0, 2);
        send("s35.b3", 1'b1, 1, 3);
        check("s35.cnt", int'(match_cnt), exp_cnt(1));

        // Reset mid-stream overrides a valid bit and clears the pattern.
        do_load(8'b0010_1011, 4'd6);
        send("p36.b1", 1'b1, 0, 1);
        send("p36.b2", 1'b0, 0, 2);
        send("p36.b3", 1'b1, 0, 3);
        send("p36.b4", 1'b0, 0, 4);
        send("p36.b5", 1'b1, 0, 5);
        rst = 1'b0; in_valid = 1'b1; in = 1'b1;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        check("rst36.stat", int'(statout), 0);
        check("rst36.cnt", int'(match_cnt), 0);
        send("s36.b1", 1'b1, 0, 0);

        // One-bit pattern: counter saturates, clear beats a same-edge match.
        do_load(8'b1, 4'd1);
        send("s37.b1", 1'b1, 1, 1);
        check("s37.c1", int'(match_cnt), exp_cnt(1));
        send("s37.b2", 1'b1, 1, 1);
        check("s37.c2", int'(match_cnt), exp_cnt(2));
        send("s37.b3", 1'b1, 1, 1);
        check("s37.c3", int'(match_cnt), exp_cnt(3));
        send("s37.b4", 1'b1, 1, 1);
        check("s37.c4", int'(match_cnt), exp_cnt(3));
        send("s37.b5", 1'b1, 1, 1);
        check("s37.c5", int'(match_cnt), exp_cnt(3));
        cnt_clr = 1'b1;
        send("s37.clr", 1'b1, 1, 1);
        cnt_clr = 1'b0;
        check("s37.clrcnt", int'(match_cnt), 0);

        // Length above PAT_W is clamped to PAT_W.
        do_load(8'b1010_0101, 4'd12);
        send("big.b1", 1'b1, 0, 1);
        send("big.b2", 1'b0, 0, 2);
        send("big.b3", 1'b1, 0, 3);
        send("big.b4", 1'b0, 0, 4);
        send("big.b5", 1'b0, 0, 5);
        send("big.b6", 1'b1, 0, 6);
        send("big.b7", 1'b0, 0, 7);
        send("big.b8", 1'b1, 1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-low reset.
REQ-006 SHALL have port in, input, 1: serial data bit.
REQ-007 SHALL have port in_valid, input, 1: in is sampled only when high.
REQ-008 SHALL have port load, input, 1: latch pat/pat_len as the new pattern.
REQ-009 SHALL have port pat, input, PAT_W: pattern; bit pat_len-1 is the first bit received, bit 0 the last.
REQ-010 SHALL have port pat_len, input, $clog2(PAT_W+1): active pattern length; 0 disables detection.
REQ-011 SHALL have port overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port cnt_clr, input, 1: clear the match counter.
REQ-013 SHALL have port out, output, 1: one-cycle registered match pulse.
REQ-014 SHALL have port statout, output, $clog2(PAT_W+1): current matched-prefix length.
REQ-015 SHALL have port match_cnt, output, CNT_W: saturating match count.

Function
REQ-016 SHALL hold registered pattern, length, a PAT_W-bit history shift register and a fill count (0..PAT_W, saturating).
REQ-017 On an edge with in_valid=1 and load=0, SHALL shift in into history bit 0 and increment fill.
REQ-018 SHALL declare a match on that edge when fill+1 >= len, len != 0, and the low len history bits, including the new bit, equal pat[len-1:0].
REQ-019 SHALL register out=1 for exactly the cycle after the matching edge; otherwise out=0, including on edges with in_valid=0.
REQ-020 With overlap=1, SHALL leave fill unchanged by a match; with overlap=0, SHALL clear fill to 0 on a match so the matching bits are not reused.
REQ-021 SHALL register statout as the largest k <= min(fill, len) for which the last k received bits equal the first k pattern bits, evaluated after each sampled bit; statout SHALL equal len on a match edge.
REQ-022 With in_valid=0, SHALL hold the history, fill and statout registers.
REQ-023 On load=1, SHALL latch pat and pat_len, clear fill and statout, and force out=0; the in bit on that edge SHALL be dropped; load SHALL take priority over in_valid.
REQ-024 With pat_len > PAT_W, SHALL treat the value as PAT_W.
REQ-025 On a match, match_cnt SHALL increment on the same edge, saturate at all-ones, and never wrap.
REQ-026 If cnt_clr and a match occur on the same edge, match_cnt SHALL become 0 (clear wins).
REQ-027 The overlap input SHALL be sampled every edge; changing it mid-stream SHALL affect only subsequent matches.

Reset
REQ-028 On rst=0 at an edge: out=0, statout=0, match_cnt=0, fill=0, history=0, pattern=PAT_W'b0, len=0 (detection disabled until the first load).
REQ-029 Reset SHALL override load, in_valid and cnt_clr; reset mid-stream SHALL discard any partial match.

Configuration
REQ-030 Macro SEQ_MATCH_CNT_EN: when defined, the match counter and cnt_clr behave per REQ-025/026; when undefined, the counter logic is omitted, match_cnt is tied to 0, and cnt_clr is ignored.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the default PAT_W/CNT_W constants and a length-width function returning $clog2(PAT_W+1).
REQ-032 The combinational longest-prefix computation (REQ-021) SHALL be a sub-module named seq_prefix_match with inputs history, pattern, len and fill, and output k.

Verification
REQ-033 Load pat=6'b101011, len=6, overlap=1; stream 1,0,1,0,1,0,1,0,1,1 -> a single out pulse one cycle after the 10th bit; match_cnt=1; statout sequence 1,2,3,4,5,4,5,4,5,6.
REQ-034 Load pat=2'b11, len=2; stream 1,1,1,1 -> overlap=1: 3 pulses (after bits 2, 3 and 4), match_cnt=3; overlap=0: 2 pulses (after bits 2 and 4), match_cnt=2.
REQ-035 Stream 1,0,1,0,1 into pattern 101011, then load pat=3'b011, len=3 with in_valid=1 and in=1 -> bit dropped, statout=0; then stream 0,1,1 -> pulse after the final 1.
REQ-036 Assert rst=0 for one edge after 5 bits of 101011, then send 1 -> no pulse, statout=0, match_cnt=0, len=0.
REQ-037 CNT_W=2, pattern 1, len=1, stream 5 ones -> match_cnt 1,2,3,3,3; cnt_clr on the same edge as a match -> match_cnt=0.
REQ-038 With SEQ_MATCH_CNT_EN undefined, rerun REQ-034 -> pulses unchanged, match_cnt stays 0.
